// File: rtl/xnor_share_arb_pkg.sv
// Shared constants, ID width derivation and operand bus type for the XNOR compare arbiter.
package xnor_share_arb_pkg;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned DW        = 4;

    // Requester ID width; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned ID_W_DEF = id_width(N_REQ_DEF);

    // Packed operand bus, requester i at bits [i*DW +: DW].
    typedef logic [N_REQ_DEF*DW-1:0] opnd_bus_t;

endpackage

// File: rtl/xnor_share_arb_if.sv
// Requester/consumer bundle of the shared XNOR compare arbiter.
interface xnor_share_arb_if
    import xnor_share_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF
) ();

    localparam int unsigned ID_W = id_width(N_REQ);

    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] a_in;
    logic [N_REQ*DW-1:0] b_in;
    logic [N_REQ-1:0]    gnt;
    logic                res_valid;
    logic                res_ready;
    logic [DW-1:0]       res_y;
    logic [ID_W-1:0]     res_id;
    logic                res_match;

    // Driver of requests and consumer of results.
    modport master (
        output req, a_in, b_in, res_ready,
        input  gnt, res_valid, res_y, res_id, res_match
    );

    // The arbiter itself.
    modport slave (
        input  req, a_in, b_in, res_ready,
        output gnt, res_valid, res_y, res_id, res_match
    );

endinterface

// File: rtl/xnor4_cell.sv
// 4-bit bitwise XNOR cell.
module xnor4_cell (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] y_o
);

    assign y_o = ~(a_i ^ b_i);

endmodule

// File: rtl/xnor_share_arb_rr_pick.sv
// Combinational round-robin one-hot picker: first request after last_id, wrapping.
module xnor_share_arb_rr_pick
    import xnor_share_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_id_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o
);

    logic [ID_W-1:0] cand;
    logic            found;

    // N_REQ is a power of two, so ID_W-bit addition wraps modulo N_REQ; k = N_REQ lands on last_id.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            cand = last_id_i + ID_W'(k);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = cand;
            end
        end
    end

endmodule

// File: rtl/xnor_share_arb.sv
// Round-robin sharing of one 4-bit XNOR compare unit with a registered valid/ready result.
module xnor_share_arb
    import xnor_share_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    xnor_share_arb_if.slave bus
);

    localparam int unsigned ID_W = id_width(N_REQ);

    logic [ID_W-1:0]  last_id_q, last_id_d;
    logic             res_valid_q, res_valid_d;
    logic [DW-1:0]    res_y_q, res_y_d;
    logic [ID_W-1:0]  res_id_q, res_id_d;
    logic             res_match_q, res_match_d;

    logic [N_REQ-1:0] pick_gnt_c;
    logic [ID_W-1:0]  pick_idx_c;
    logic [N_REQ-1:0] gnt_c;
    logic             can_load_c;
    logic             grant_c;
    logic [DW-1:0]    a_sel_c, b_sel_c, y_c;

    xnor_share_arb_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i     (bus.req),
        .last_id_i (last_id_q),
        .gnt_o     (pick_gnt_c),
        .idx_o     (pick_idx_c)
    );

    // Grant only when the output register can take a result and reset is released.
    always_comb begin
        can_load_c = !res_valid_q || bus.res_ready;
        gnt_c      = (rst_n && can_load_c) ? pick_gnt_c : '0;
        grant_c    = |gnt_c;
    end

    // Select the granted requester's operand pair.
    always_comb begin
        a_sel_c = '0;
        b_sel_c = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (pick_idx_c == ID_W'(i)) begin
                a_sel_c = bus.a_in[i*DW +: DW];
                b_sel_c = bus.b_in[i*DW +: DW];
            end
        end
    end

    xnor4_cell u_xnor (
        .a_i (a_sel_c),
        .b_i (b_sel_c),
        .y_o (y_c)
    );

    // Next state: load on grant, otherwise drain when the consumer accepts.
    always_comb begin
        last_id_d   = last_id_q;
        res_valid_d = res_valid_q;
        res_y_d     = res_y_q;
        res_id_d    = res_id_q;
        res_match_d = res_match_q;
        if (grant_c) begin
            last_id_d   = pick_idx_c;
            res_valid_d = 1'b1;
            res_y_d     = y_c;
            res_id_d    = pick_idx_c;
            res_match_d = &y_c;
        end else if (bus.res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_id_q   <= ID_W'(N_REQ - 1);
            res_valid_q <= 1'b0;
            res_y_q     <= '0;
            res_id_q    <= '0;
            res_match_q <= 1'b0;
        end else begin
            last_id_q   <= last_id_d;
            res_valid_q <= res_valid_d;
            res_y_q     <= res_y_d;
            res_id_q    <= res_id_d;
            res_match_q <= res_match_d;
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.res_valid = res_valid_q;
    assign bus.res_y     = res_y_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_match = res_match_q;

endmodule

// File: tb/tb_xnor_share_arb.sv
// Directed plus randomized check of xnor_share_arb against a behavioural model.
module tb_xnor_share_arb;
    import xnor_share_arb_pkg::*;

    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    xnor_share_arb_if #(.N_REQ(N)) bus ();

    xnor_share_arb #(.N_REQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    int        m_last;
    bit        m_valid;
    logic [3:0] m_y;
    int        m_id;
    bit        m_match;

    logic [3:0] obs_gnt;
    opnd_bus_t  a_v, b_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected grant from the arbitration rules.
    function automatic logic [3:0] model_gnt(input bit r, input logic [3:0] rq, input bit rdy);
        logic [3:0] g;
        g = 4'b0;
        if (r && (!m_valid || rdy)) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (g == 4'b0 && rq[i]) g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    // One clock: drive, compare at negedge, advance model at posedge.
    task automatic cyc(input bit r, input logic [3:0] rq, input bit rdy, input bit chk_en);
        logic [3:0] eg;
        int         gi;
        logic [3:0] av, bv;
        rst_n         = r;
        bus.req       = rq;
        bus.a_in      = a_v;
        bus.b_in      = b_v;
        bus.res_ready = rdy;
        eg = model_gnt(r, rq, rdy);
        @(negedge clk);
        obs_gnt = bus.gnt;
        if (chk_en) begin
            chk("gnt",       32'(bus.gnt),       32'(eg));
            chk("res_valid", 32'(bus.res_valid), 32'(m_valid));
            chk("res_y",     32'(bus.res_y),     32'(m_y));
            chk("res_id",    32'(bus.res_id),    32'(m_id));
            chk("res_match", 32'(bus.res_match), 32'(m_match));
        end
        @(posedge clk);
        if (!r) begin
            m_last = N - 1; m_valid = 0; m_y = 4'h0; m_id = 0; m_match = 0;
        end else if (eg != 4'b0) begin
            gi = 0;
            for (int i = 0; i < N; i++) if (eg[i]) gi = i;
            av = a_v[gi*4 +: 4];
            bv = b_v[gi*4 +: 4];
            m_y     = 4'(4'hF - (av ^ bv));
            m_match = (av == bv);
            m_id    = gi;
            m_last  = gi;
            m_valid = 1;
        end else if (rdy) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        a_v[i*4 +: 4] = a;
        b_v[i*4 +: 4] = b;
    endtask

    initial begin
        logic [3:0] held_y;
        checks = 0; errors = 0;
        m_last = N - 1; m_valid = 0; m_y = 0; m_id = 0; m_match = 0;
        a_v = '0; b_v = '0;
        rst_n = 1'b0;
        bus.req = '0; bus.a_in = '0; bus.b_in = '0; bus.res_ready = 1'b0;

        cyc(0, 4'b0000, 1, 0);
        cyc(0, 4'b0000, 1, 0);
        cyc(0, 4'b1111, 1, 1);

        // Equal operands on requester 0
        set_op(0, 4'hA, 4'hA);
        cyc(1, 4'b0001, 1, 1);
        chk("t1_gnt", 32'(obs_gnt), 32'h1);
        chk("t1_valid", 32'(bus.res_valid), 32'h1);
        chk("t1_y", 32'(bus.res_y), 32'hF);
        chk("t1_id", 32'(bus.res_id), 32'h0);
        chk("t1_match", 32'(bus.res_match), 32'h1);

        // Requester 1 mismatches
        set_op(1, 4'hC, 4'h3);
        cyc(1, 4'b0010, 1, 1);
        chk("t2_y", 32'(bus.res_y), 32'h0);
        chk("t2_id", 32'(bus.res_id), 32'h1);
        chk("t2_match", 32'(bus.res_match), 32'h0);
        set_op(1, 4'h5, 4'h4);
        cyc(1, 4'b0010, 1, 1);
        chk("t3_y", 32'(bus.res_y), 32'hE);
        chk("t3_match", 32'(bus.res_match), 32'h0);

        // Park pointer on 3, then all requesting rotates from 0
        set_op(2, 4'h7, 4'h7); set_op(3, 4'h1, 4'h8);
        cyc(1, 4'b1000, 1, 1);
        for (int k = 0; k < 8; k++) begin
            cyc(1, 4'b1111, 1, 1);
            chk("rot_gnt", 32'(obs_gnt), 32'(4'b0001 << (k % 4)));
            chk("rot_valid", 32'(bus.res_valid), 32'h1);
        end

        // Back-pressure for three cycles
        held_y = bus.res_y;
        for (int k = 0; k < 3; k++) begin
            cyc(1, 4'b0100, 0, 1);
            chk("bp_gnt", 32'(obs_gnt), 32'h0);
            chk("bp_y_hold", 32'(bus.res_y), 32'(held_y));
        end
        cyc(1, 4'b0100, 1, 1);
        chk("bp_rel_gnt", 32'(obs_gnt), 32'h4);
        chk("bp_rel_id", 32'(bus.res_id), 32'h2);

        // Wrap past 3
        cyc(1, 4'b0101, 1, 1);
        chk("wrap_gnt", 32'(obs_gnt), 32'h1);
        cyc(1, 4'b1000, 1, 1);
        cyc(1, 4'b1001, 1, 1);
        chk("wrap3_gnt", 32'(obs_gnt), 32'h1);

        // Reset while a result is pending
        cyc(0, 4'b1111, 1, 1);
        chk("rst_gnt", 32'(obs_gnt), 32'h0);
        chk("rst_valid", 32'(bus.res_valid), 32'h0);
        cyc(1, 4'b1111, 1, 1);
        chk("rst_first_gnt", 32'(obs_gnt), 32'h1);

        // Drain without load
        cyc(1, 4'b0000, 1, 1);
        chk("drain_valid", 32'(bus.res_valid), 32'h0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            a_v = opnd_bus_t'($urandom);
            b_v = opnd_bus_t'($urandom);
            if ($urandom_range(0, 3) == 0) b_v = a_v ^ opnd_bus_t'(16'h1 << $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) b_v = a_v;
            cyc(($urandom_range(0, 49) != 0), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 9) < 7), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xnor_share_arb.md
Name: xnor_share_arb

Overview:
- Round-robin arbiter that shares one 4-bit bitwise-XNOR compare unit between N_REQ requesters.
- Each requester presents an operand pair (a, b) with a request.
- The block grants one requester per cycle and computes y = ~(a ^ b) plus an all-bits-equal flag.
- The result is held in an output register with a valid/ready handshake.
- Sits between nibble-compare clients (pattern matchers, checksum checkers) and a downstream consumer.

Parameters:
- N_REQ, 4, number of requesters; power of two, 2..8.
- ID_W, $clog2(N_REQ), width of the requester ID field; derived, not overridden.
- DW, 4, operand width; fixed at 4 to match the XNOR cell.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- req  in  N_REQ  per-requester request; bit i high means requester i has valid operands
- a_in  in  N_REQ*DW  packed operand A; requester i at bits [i*DW +: DW]
- b_in  in  N_REQ*DW  packed operand B; same packing as a_in
- gnt  out  N_REQ  one-hot combinational grant; bit i high means requester i's operands are taken this cycle
- res_valid  out  1  output register holds a result
- res_ready  in  1  consumer accepts the result this cycle
- res_y  out  DW  registered ~(a ^ b) of the granted pair
- res_id  out  ID_W  index of the requester that produced res_y
- res_match  out  1  registered flag, 1 when a == b (all bits of y set)

Behaviour:
- Reset: one clock was decided, with synchronous active-low reset on clk / rst_n. While rst_n == 0 at a rising edge:
  - res_valid=0, res_y=0, res_id=0, res_match=0.
  - Round-robin pointer last_id = N_REQ-1, so requester 0 has first priority.
  - gnt is forced to 0 whenever rst_n == 0.
- Accept condition: can_load = !res_valid || res_ready. When can_load && |req, exactly one gnt bit is high in that cycle. Otherwise gnt = 0.
- Arbitration: the search starts at (last_id+1) mod N_REQ and wraps, and selects the first i with req[i]=1. The pointer updates to the granted index only on a grant.
- Latency: 1 cycle. Operands are sampled on the grant edge. res_valid=1 with the matching res_y/res_id/res_match appears on the next cycle.
- Throughput: 1 result per cycle while res_ready stays high.
- Back-pressure: while res_valid && !res_ready:
  - res_* hold stable.
  - gnt = 0.
  - The pointer is frozen.
- Drain and load in the same cycle: when res_valid && res_ready && a grant occur together, the register reloads with the new result and res_valid stays 1.
- Drain without load: res_valid && res_ready && !(|req) gives res_valid=0 on the next cycle. res_y/res_id/res_match keep their last values (don't-care).
- Requester protocol:
  - Hold req[i] and operands stable until gnt[i] is seen.
  - Keeping req[i] high after a grant requests another operation.
  - Dropping req[i] before its grant is legal; no result is produced for it.
- Fairness: with all req bits high, grants rotate 0,1,2,3,0,... Any continuously requesting client is served within N_REQ grants.
- Arithmetic: res_y = bitwise XNOR, no carry. res_match = &res_y.
- Reset mid-operation: a pending result is discarded, a grant in the same cycle is suppressed, and the pointer returns to N_REQ-1.

Decomposition:
- Shared package holds:
  - N_REQ_DEF=4 and DW=4 constants.
  - ID_W derivation.
  - A typedef for the packed operand bus.
- Natural sub-module: rr_pick. It takes a combinational round-robin one-hot picker with inputs req and last_id, and produces a one-hot grant and its encoded index.
- The XNOR itself reuses the team's existing 4-bit XNOR cell, instantiated once on the muxed operands.

Test Plan:
- Reset, then req=0001, a0=4'hA, b0=4'hA, res_ready=1 -> gnt=0001 in cycle 0; next cycle res_valid=1, res_y=4'hF, res_id=0, res_match=1.
- req=0010, a1=4'hC, b1=4'h3 -> res_y=4'h0, res_id=1, res_match=0; a1=4'h5, b1=4'h4 -> res_y=4'hE, res_match=0.
- req=1111 held 8 cycles with res_ready=1 -> gnt sequence 0001,0010,0100,1000,0001,... and res_valid continuously 1.
- Result pending, res_ready=0 for 3 cycles, req=0100 -> gnt=0 and res_* stable for 3 cycles; on res_ready=1, gnt=0100 in the same cycle and the new result appears next cycle.
- Grant to requester 2 -> pointer at 2; then req=0101 -> next grant is 0001 (wrap past 3). req=1001 after a grant to 3 -> grant is 0001.
- rst_n=0 for one cycle while res_valid=1 and req=1111 -> gnt=0 that cycle; next cycle res_valid=0; the first grant after release is 0001.
